ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning first fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 8, meaning fetch-queue entries (power of two, >=4).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ibus  cpu_ibus_if.master  --  read, address[31:0] out; stall, rddata[63:0] in.
REQ-006 SHALL have port redirect  input  1  flush queue and restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc  input  32  new fetch address, valid when redirect=1.
REQ-008 SHALL have port inst_valid  output  1  queue head valid.
REQ-009 SHALL have port inst  output  32  head instruction word.
REQ-010 SHALL have port inst_pc  output  32  head instruction address.
REQ-011 SHALL have port inst_adel  output  1  head carries instruction address-error exception.
REQ-012 SHALL have port inst_ready  input  1  consumer pops head when inst_valid and inst_ready both 1.

Function
REQ-013 Bus transfer SHALL complete in the cycle read=1 and stall=0; rddata sampled that cycle; rddata[31:0] = word at address, [63:32] = word at address+4.
REQ-014 ibus.address SHALL be {pc[31:3],3'b000}; read and address SHALL stay stable while stall=1.
REQ-015 States SHALL be FETCH, STALL, DRAIN, HALT.
REQ-016 FETCH: read=1 only when queue free entries >=2 and not HALT; stall=1 -> STALL; completion -> push, stay FETCH.
REQ-017 STALL: read held; stall=0 -> push, FETCH; redirect seen -> DRAIN.
REQ-018 DRAIN: read/address held until stall=0, returned data discarded, then FETCH at latched redirect_pc; later redirect in DRAIN overwrites latched pc.
REQ-019 Push count: pc[2]=0 -> two entries (pc, pc+4); pc[2]=1 -> one entry (upper word, pc); next pc = {pc[31:3]+1,3'b000}, wrapping modulo 2^32.
REQ-020 pc[1:0]!=0: no bus read; one entry with inst=0, inst_adel=1 pushed when space; then HALT.
REQ-021 HALT: read=0 until redirect.
REQ-022 Redirect in FETCH or HALT: queue cleared same edge, any same-cycle completion discarded, pc<=redirect_pc, next state FETCH; read=1 earliest one cycle after redirect.
REQ-023 Redirect in STALL: queue cleared same edge, transition to DRAIN.
REQ-024 Redirect SHALL override simultaneous pop and push; popped head is still counted consumed by the consumer.
REQ-025 Queue SHALL support push 0/1/2 and pop 0/1 in one cycle, FIFO order preserved, never overflows (REQ-016 guard), inst_valid=0 when empty.
REQ-026 Outputs inst/inst_pc/inst_adel SHALL be registered queue-head contents, zero when empty.

Reset
REQ-027 On rst: pc=RESET_PC, state=FETCH, queue empty, inst_valid=0, inst=0, inst_pc=0, inst_adel=0, read=0, address=0, latched redirect pc=0.
REQ-028 rst mid-STALL/DRAIN SHALL abandon the transfer; first read after release issues from RESET_PC no earlier than first clk edge after rst deasserts.

Structure
REQ-029 Shared package SHALL hold RESET_PC default, QUEUE_DEPTH default, fetch_state_t enum and fetch_entry_t {pc, inst, adel}.
REQ-030 Queue SHALL be sub-module fetch_queue (2-write, 1-read, synchronous flush, async reset).

Verification
REQ-031 Reset, stall=0, rddata={32'h2,32'h1}: read at 0xBFC00000; queue yields (0xBFC00000,1),(0xBFC00004,2); next address 0xBFC00008.
REQ-032 redirect_pc=0x80000004: read at 0x80000000; only (0x80000004, rddata[63:32]) pushed.
REQ-033 stall=1 for 5 cycles then redirect to 0x80001000 in cycle 2: address held 0xBFC00000 until stall drops, data dropped, next read 0x80001000, queue empty meanwhile.
REQ-034 redirect_pc=0x80000002: no read; one entry inst_adel=1, inst_pc=0x80000002; read stays 0 until next redirect.
REQ-035 inst_ready=0 throughout: read deasserts with 7 or 8 entries filled; no overflow; order intact on resume.
REQ-036 pc=0xFFFFFFF8 fetch: next address 0x00000000; rst asserted mid-stall -> read=0 immediately, restart at 0xBFC00000.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared defaults, fetch FSM state and fetch-queue entry type
package ifetch_unit_pkg;

   localparam logic [31:0] DEF_RESET_PC    = 32'hBFC00000;
   localparam int          DEF_QUEUE_DEPTH = 8;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      STALL = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } fetch_entry_t;

   // Start of the next 8-byte fetch line; the 29-bit add wraps naturally at 2^32.
   function automatic logic [31:0] next_line(input logic [31:0] pc);
      return {pc[31:3] + 29'd1, 3'b000};
   endfunction

endpackage

// File: rtl/cpu_ibus_if.sv
// rtl/cpu_ibus_if.sv - 64-bit instruction read bus with stall handshake
interface cpu_ibus_if;
   logic        read;
   logic [31:0] address;
   logic        stall;
   logic [63:0] rddata;

   modport master (output read, output address, input stall, input rddata);
   modport slave  (input read, input address, output stall, output rddata);
endinterface

// File: rtl/ifetch_unit_fetch_queue.sv
// rtl/ifetch_unit_fetch_queue.sv - 2-write/1-read fetch FIFO with flush and registered head
module fetch_queue
   import ifetch_unit_pkg::*;
#(
   parameter int DEPTH = DEF_QUEUE_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_wr_en0,
   input  fetch_entry_t           i_wr_data0,
   input  logic                   i_wr_en1,
   input  fetch_entry_t           i_wr_data1,
   input  logic                   i_rd_en,
   output fetch_entry_t           o_head,
   output logic                   o_valid,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_pop;
   logic [AW-1:0] w_rd_nxt;
   logic [AW-1:0] w_wr_ptr1;
   logic [CW-1:0] w_left;
   logic [CW-1:0] w_cnt_nxt;
   fetch_entry_t  w_head_nxt;

   assign w_pop     = i_rd_en && (r_count != '0);
   assign w_rd_nxt  = r_rd_ptr + AW'(w_pop);
   assign w_wr_ptr1 = r_wr_ptr + AW'(1);
   assign w_left    = r_count - CW'(w_pop);
   assign w_cnt_nxt = w_left + CW'(i_wr_en0) + CW'(i_wr_en1);
   assign o_count   = r_count;

   // The head is precomputed so it can be registered: if the queue drains this
   // cycle, the new head is the entry being written rather than a stored one.
   always_comb begin
      w_head_nxt = '0;
      if (w_left != '0) begin
         w_head_nxt = r_mem[w_rd_nxt];
      end else if (i_wr_en0) begin
         w_head_nxt = i_wr_data0;
      end
   end

   always_ff @(posedge clk) begin
      if (!i_flush) begin
         if (i_wr_en0) r_mem[r_wr_ptr]  <= i_wr_data0;
         if (i_wr_en1) r_mem[w_wr_ptr1] <= i_wr_data1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         o_head   <= '0;
         o_valid  <= 1'b0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         o_head   <= '0;
         o_valid  <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_nxt;
         r_wr_ptr <= r_wr_ptr + AW'(i_wr_en0) + AW'(i_wr_en1);
         r_count  <= w_cnt_nxt;
         o_head   <= w_head_nxt;
         o_valid  <= (w_cnt_nxt != '0);
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch: bus sequencing FSM feeding the fetch queue
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
   parameter int          QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   cpu_ibus_if.master  ibus,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_adel,
   input  logic        inst_ready
);
   localparam int            CW      = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

   fetch_state_t  r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_redir_pc;
   logic [31:0]   r_addr;
   logic          r_read;

   logic          w_done;
   logic          w_pop;
   logic          w_misal;
   logic          w_space1;
   logic          w_room2;
   logic          w_wr_en0;
   logic          w_wr_en1;
   fetch_entry_t  w_wr_d0;
   fetch_entry_t  w_wr_d1;
   fetch_entry_t  w_head;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_cnt_nxt;

   assign ibus.read    = r_read;
   assign ibus.address = r_addr;

   assign w_done    = r_read && !ibus.stall;
   assign w_pop     = inst_valid && inst_ready;
   assign w_misal   = (r_pc[1:0] != 2'b00);
   assign w_space1  = (w_count != DEPTH_C) || w_pop;
   assign w_cnt_nxt = redirect ? '0 : (w_count + CW'(w_wr_en0) + CW'(w_wr_en1) - CW'(w_pop));
   // Issuing only with two free slots after this edge guarantees the completion fits.
   assign w_room2   = ((DEPTH_C - w_cnt_nxt) >= CW'(2));

   always_comb begin
      w_wr_en0 = 1'b0;
      w_wr_en1 = 1'b0;
      w_wr_d0  = '0;
      w_wr_d1  = '0;
      if (!redirect) begin
         if ((r_state == FETCH || r_state == STALL) && w_done) begin
            w_wr_en0 = 1'b1;
            if (!r_pc[2]) begin
               w_wr_d0  = '{pc: r_pc, inst: ibus.rddata[31:0], adel: 1'b0};
               w_wr_en1 = 1'b1;
               w_wr_d1  = '{pc: r_pc + 32'd4, inst: ibus.rddata[63:32], adel: 1'b0};
            end else begin
               w_wr_d0  = '{pc: r_pc, inst: ibus.rddata[63:32], adel: 1'b0};
            end
         end else if (r_state == FETCH && !r_read && w_misal && w_space1) begin
            w_wr_en0 = 1'b1;
            w_wr_d0  = '{pc: r_pc, inst: 32'd0, adel: 1'b1};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= FETCH;
         r_pc       <= RESET_PC;
         r_redir_pc <= '0;
         r_read     <= 1'b0;
         r_addr     <= '0;
      end else begin
         case (r_state)
            FETCH, STALL: begin
               // A stalled transfer cannot be withdrawn, so a redirect must drain it.
               if (r_read && ibus.stall) begin
                  if (redirect) begin
                     r_redir_pc <= redirect_pc;
                     r_state    <= DRAIN;
                  end else begin
                     r_state    <= STALL;
                  end
               end else if (redirect) begin
                  r_pc    <= redirect_pc;
                  r_state <= FETCH;
                  r_read  <= 1'b0;
               end else if (r_read) begin
                  r_pc    <= next_line(r_pc);
                  r_addr  <= next_line(r_pc);
                  r_read  <= w_room2;
                  r_state <= FETCH;
               end else if (w_misal) begin
                  if (w_space1) r_state <= HALT;
               end else if (w_room2) begin
                  r_read <= 1'b1;
                  r_addr <= {r_pc[31:3], 3'b000};
               end
            end
            DRAIN: begin
               if (redirect) r_redir_pc <= redirect_pc;
               if (!ibus.stall) begin
                  r_pc    <= redirect ? redirect_pc : r_redir_pc;
                  r_read  <= 1'b0;
                  r_state <= FETCH;
               end
            end
            HALT: begin
               if (redirect) begin
                  r_pc    <= redirect_pc;
                  r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (redirect),
      .i_wr_en0   (w_wr_en0),
      .i_wr_data0 (w_wr_d0),
      .i_wr_en1   (w_wr_en1),
      .i_wr_data1 (w_wr_d1),
      .i_rd_en    (w_pop),
      .o_head     (w_head),
      .o_valid    (inst_valid),
      .o_count    (w_count)
   );

   assign inst      = w_head.inst;
   assign inst_pc   = w_head.pc;
   assign inst_adel = w_head.adel;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit against an instruction-stream model
module tb_ifetch_unit;

   localparam logic [31:0] RPC = 32'hBFC00000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_adel;
   logic        inst_ready;

   int   errors = 0;
   int   checks = 0;
   int   pops   = 0;
   exp_t exp_q[$];
   bit   seg_mis = 1'b0;

   cpu_ibus_if bus ();

   ifetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .ibus        (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_adel   (inst_adel),
      .inst_ready  (inst_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
   endfunction

   task automatic chk(input bit ok, input string nm, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Expected stream after a (re)start at p: consecutive words, or a single address-error entry.
   task automatic load_seg(input logic [31:0] p);
      logic [31:0] a;
      exp_q.delete();
      if (p[1:0] != 2'b00) begin
         seg_mis = 1'b1;
         exp_q.push_back('{pc: p, inst: 32'd0, adel: 1'b1});
      end else begin
         seg_mis = 1'b0;
         for (int i = 0; i < 80; i++) begin
            a = p + 32'(4 * i);
            exp_q.push_back('{pc: a, inst: memw(a), adel: 1'b0});
         end
      end
   endtask

   task automatic wait_read(input string nm, input logic [31:0] skip);
      int n;
      n = 0;
      do begin
         @(negedge clk); #2;
         n++;
      end while (!(bus.read && bus.address != skip) && n < 20);
      chk(bus.read && bus.address != skip, {nm, "_timeout"}, 96'(n), 96'(20));
   endtask

   function automatic logic [31:0] pick_pc();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 5))
         0, 5:    return r & ~32'h3;
         1:       return (r & ~32'h7) | 32'h4;
         2:       return (r & ~32'h3) | 32'($urandom_range(1, 3));
         3:       return 32'hFFFFFFF8;
         default: return 32'hFFFFFFFC;
      endcase
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         bus.rddata = {memw(bus.address + 32'd4), memw(bus.address)};
      end
   end

   initial begin
      bit          p_read;
      bit          p_stall;
      logic [31:0] p_addr;
      exp_t        e;
      p_read  = 1'b0;
      p_stall = 1'b0;
      p_addr  = '0;
      forever begin
         @(negedge clk); #1;
         if (rst) begin
            chk(!bus.read && bus.address == 32'd0, "rst_bus", {bus.read, bus.address}, 96'd0);
            chk(!inst_valid && inst == 32'd0 && inst_pc == 32'd0 && !inst_adel, "rst_head",
                {inst_valid, inst_adel, inst_pc, inst}, 96'd0);
            load_seg(RPC);
            p_read  = 1'b0;
            p_stall = 1'b0;
         end else begin
            if (p_read && p_stall)
               chk(bus.read && bus.address == p_addr, "bus_hold", {bus.read, bus.address}, {1'b1, p_addr});
            if (bus.read)
               chk(bus.address[2:0] == 3'b000, "addr_align", 96'(bus.address), 96'({bus.address[31:3], 3'b000}));
            if (seg_mis && !(p_read && p_stall))
               chk(!bus.read, "halt_read", 96'(bus.read), 96'd0);
            if (!inst_valid)
               chk(inst == 32'd0 && inst_pc == 32'd0 && !inst_adel, "empty_zero", {inst_adel, inst_pc, inst}, 96'd0);
            if (inst_valid && inst_ready) begin
               pops++;
               if (exp_q.size() == 0) begin
                  chk(exp_q.size() != 0, "unexpected_pop", {inst_adel, inst_pc, inst}, 96'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk(inst_pc == e.pc && inst == e.inst && inst_adel == e.adel, "pop_data",
                      {inst_adel, inst_pc, inst}, {e.adel, e.pc, e.inst});
               end
            end
            if (redirect) load_seg(redirect_pc);
            p_read  = bus.read;
            p_stall = bus.stall;
            p_addr  = bus.address;
         end
      end
   end

   initial begin
      logic [31:0] a;
      int          since;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b0;
      bus.stall   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      wait_read("first_read", 32'h1);
      chk(bus.address == RPC, "first_read_addr", 96'(bus.address), 96'(RPC));
      @(negedge clk); #2;
      chk(inst_valid && inst_pc == RPC && inst == memw(RPC), "first_head", {inst_valid, inst_pc, inst}, {1'b1, RPC, memw(RPC)});
      chk(bus.read && bus.address == RPC + 32'd8, "second_addr", {bus.read, bus.address}, {1'b1, RPC + 32'd8});

      repeat (20) @(negedge clk);
      #2;
      chk(!bus.read && inst_valid, "full_read_off", {bus.read, inst_valid}, {1'b0, 1'b1});
      @(negedge clk);
      inst_ready = 1'b1;
      repeat (12) @(negedge clk);

      redirect = 1'b1; redirect_pc = 32'h80000004;
      @(negedge clk);
      redirect = 1'b0;
      wait_read("pc4_read", 32'h1);
      chk(bus.address == 32'h80000000, "pc4_addr", 96'(bus.address), 96'(32'h80000000));
      @(negedge clk); #2;
      chk(inst_valid && inst_pc == 32'h80000004 && inst == memw(32'h80000004), "pc4_head",
          {inst_valid, inst_pc, inst}, {1'b1, 32'h80000004, memw(32'h80000004)});

      @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h80000002; inst_ready = 1'b0;
      @(negedge clk);
      redirect = 1'b0;
      @(negedge clk); #2;
      chk(inst_valid && inst_adel && inst_pc == 32'h80000002 && inst == 32'd0, "adel_head",
          {inst_valid, inst_adel, inst_pc, inst}, {1'b1, 1'b1, 32'h80000002, 32'd0});
      @(negedge clk);
      inst_ready = 1'b1;
      repeat (10) @(negedge clk);
      #2;
      chk(!bus.read && !inst_valid, "halt_idle", {bus.read, inst_valid}, 96'd0);

      @(negedge clk);
      bus.stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h90000000;
      @(negedge clk);
      redirect = 1'b0;
      wait_read("stall_read", 32'h1);
      a = bus.address;
      chk(a == 32'h90000000, "stall_addr", 96'(a), 96'(32'h90000000));
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h80001000;
      @(negedge clk);
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #2;
         chk(bus.read && bus.address == a && !inst_valid, "drain_hold", {bus.read, inst_valid, bus.address}, {1'b1, 1'b0, a});
      end
      @(negedge clk);
      bus.stall = 1'b0;
      wait_read("drain_next", a);
      chk(bus.address == 32'h80001000, "drain_next_addr", 96'(bus.address), 96'(32'h80001000));

      @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'hFFFFFFF8;
      @(negedge clk);
      redirect = 1'b0;
      wait_read("wrap_read", 32'h1);
      chk(bus.address == 32'hFFFFFFF8, "wrap_first", 96'(bus.address), 96'(32'hFFFFFFF8));
      wait_read("wrap_next", 32'hFFFFFFF8);
      chk(bus.address == 32'h0, "wrap_addr", 96'(bus.address), 96'd0);
      @(negedge clk);
      bus.stall = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      chk(bus.read, "stall_hold", 96'(bus.read), 96'd1);
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk(!bus.read, "rst_async", 96'(bus.read), 96'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0; bus.stall = 1'b0;
      wait_read("rst_restart", 32'h1);
      chk(bus.address == RPC, "rst_restart_addr", 96'(bus.address), 96'(RPC));

      since = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         bus.stall  = ($urandom_range(0, 3) == 0);
         inst_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0 || since >= 48) begin
            redirect    = 1'b1;
            redirect_pc = pick_pc();
            since       = 0;
         end else begin
            redirect = 1'b0;
            since++;
         end
      end
      @(negedge clk);
      redirect = 1'b0; bus.stall = 1'b0; inst_ready = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      chk(pops >= 200, "progress", 96'(pops), 96'(200));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
